// File: rtl/alu_arbiter.sv
// Shares one registered ALU between two requesters; ALU_ARB_FIXED_PRIO_EN selects fixed priority (req0 wins), default round-robin.
// Accept-to-rsp_valid latency ALU_LATENCY+2, one op in flight; rsp_ready low stalls the block and holds off new requests.
module alu_arbiter #(
    parameter int NUMBITS     = 8,
    parameter int ALU_LATENCY = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [2:0]         req0_opcode,
    input  logic [NUMBITS-1:0] req0_A,
    input  logic [NUMBITS-1:0] req0_B,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [2:0]         req1_opcode,
    input  logic [NUMBITS-1:0] req1_A,
    input  logic [NUMBITS-1:0] req1_B,
    output logic [NUMBITS-1:0] alu_A,
    output logic [NUMBITS-1:0] alu_B,
    output logic [2:0]         alu_opcode,
    input  logic [NUMBITS-1:0] alu_result,
    input  logic               alu_carryout,
    input  logic               alu_overflow,
    input  logic               alu_zero,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [NUMBITS-1:0] rsp_result,
    output logic               rsp_carryout,
    output logic               rsp_overflow,
    output logic               rsp_zero,
    output logic               busy
);
    localparam int CNT_W = $clog2(ALU_LATENCY + 2);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             id_q;
    logic             any_valid;
    logic             grant_id;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign grant_id = ~req0_valid;
`else
    logic last_grant;
    // On a tie the requester that did not win last time goes first.
    assign grant_id = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
`endif

    assign any_valid  = req0_valid | req1_valid;
    assign req0_ready = (state == IDLE) && req0_valid && !grant_id;
    assign req1_ready = (state == IDLE) && req1_valid && grant_id;

    // alu_A/B/opcode double as the operand hold registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            id_q         <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant   <= 1'b1;
`endif
            alu_A        <= '0;
            alu_B        <= '0;
            alu_opcode   <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_result   <= '0;
            rsp_carryout <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_zero     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        alu_A      <= grant_id ? req1_A : req0_A;
                        alu_B      <= grant_id ? req1_B : req0_B;
                        alu_opcode <= grant_id ? req1_opcode : req0_opcode;
                        id_q       <= grant_id;
`ifndef ALU_ARB_FIXED_PRIO_EN
                        last_grant <= grant_id;
`endif
                        cnt        <= '0;
                        busy       <= 1'b1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(ALU_LATENCY)) begin
                        rsp_result   <= alu_result;
                        rsp_carryout <= alu_carryout;
                        rsp_overflow <= alu_overflow;
                        rsp_zero     <= alu_zero;
                        rsp_id       <= id_q;
                        rsp_valid    <= 1'b1;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: registered ALU model, per-cycle behavioural reference, directed cases and random traffic.
module tb_alu_arbiter;
    localparam int NB  = 8;
    localparam int LAT = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0] req0_opcode, req1_opcode, alu_opcode;
    logic [NB-1:0] req0_A, req0_B, req1_A, req1_B;
    logic [NB-1:0] alu_A, alu_B, alu_result;
    logic alu_carryout, alu_overflow, alu_zero;
    logic rsp_valid, rsp_ready, rsp_id;
    logic [NB-1:0] rsp_result;
    logic rsp_carryout, rsp_overflow, rsp_zero, busy;

    alu_arbiter #(.NUMBITS(NB), .ALU_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
        .req0_A(req0_A), .req0_B(req0_B),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
        .req1_A(req1_A), .req1_B(req1_B),
        .alu_A(alu_A), .alu_B(alu_B), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_carryout(alu_carryout),
        .alu_overflow(alu_overflow), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_carryout(rsp_carryout),
        .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero), .busy(busy)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Returns {carry, overflow, zero, result}.
    function automatic logic [NB+2:0] alu_fn(input logic [2:0] op, input logic [NB-1:0] a, input logic [NB-1:0] b);
        logic [NB:0]   s;
        logic [NB-1:0] r;
        logic          c, v;
        s = '0; r = '0; c = 1'b0; v = 1'b0;
        case (op)
            3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[NB-1:0]; c = s[NB]; end
            3'd1: begin s = {1'b0, a} + {1'b0, b}; r = s[NB-1:0]; c = s[NB];
                        v = (a[NB-1] == b[NB-1]) && (r[NB-1] != a[NB-1]); end
            3'd2: begin s = {1'b0, a} - {1'b0, b}; r = s[NB-1:0]; c = s[NB]; end
            3'd3: begin s = {1'b0, a} - {1'b0, b}; r = s[NB-1:0]; c = s[NB];
                        v = (a[NB-1] != b[NB-1]) && (r[NB-1] != a[NB-1]); end
            3'd4: r = a & b;
            3'd5: r = a | b;
            3'd6: r = a ^ b;
            default: begin r = a >> 1; c = a[0]; end
        endcase
        return {c, v, (r == '0), r};
    endfunction

    // Registered ALU, latency 1, sharing the arbiter's reset.
    always @(posedge clk) begin
        if (reset) {alu_carryout, alu_overflow, alu_zero, alu_result} <= '0;
        else       {alu_carryout, alu_overflow, alu_zero, alu_result} <= alu_fn(alu_opcode, alu_A, alu_B);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    typedef struct { logic id; int cyc; } acc_t;
    typedef struct { logic id; logic [NB-1:0] res; logic c, v, z; int cyc; } rsp_t;
    acc_t acc_q[$];
    rsp_t rsp_q[$];
    bit last_acc0 = 0, last_acc1 = 0;

    // Reference: one op in flight; response appears LAT+2 cycles after accept and is held until taken.
    bit            m_busy = 0, m_last = 1, m_id;
    int            m_acc_cyc;
    logic [NB+2:0] m_exp;
    logic [2:0]    m_op;
    logic [NB-1:0] m_a, m_b;
    bit            w_vld, w_id, e_r0, e_r1, e_rv;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            m_busy = 0; m_last = 1; last_acc0 = 0; last_acc1 = 0;
        end else begin
            e_r0 = 0; e_r1 = 0; e_rv = 0; w_vld = 0; w_id = 0;
            if (!m_busy) begin
                w_vld = req0_valid || req1_valid;
`ifdef ALU_ARB_FIXED_PRIO_EN
                w_id = !req0_valid;
`else
                w_id = (req0_valid && req1_valid) ? !m_last : req1_valid;
`endif
                e_r0 = w_vld && !w_id;
                e_r1 = w_vld && w_id;
            end else begin
                chk("alu_A", alu_A, m_a);
                chk("alu_B", alu_B, m_b);
                chk("alu_opcode", alu_opcode, m_op);
                e_rv = (cyc >= m_acc_cyc + LAT + 2);
                if (e_rv) begin
                    chk("rsp_id", rsp_id, m_id);
                    chk("rsp_result", rsp_result, m_exp[NB-1:0]);
                    chk("rsp_carryout", rsp_carryout, m_exp[NB+2]);
                    chk("rsp_overflow", rsp_overflow, m_exp[NB+1]);
                    chk("rsp_zero", rsp_zero, m_exp[NB]);
                end
            end
            chk("req0_ready", req0_ready, e_r0);
            chk("req1_ready", req1_ready, e_r1);
            chk("busy", busy, m_busy);
            chk("rsp_valid", rsp_valid, e_rv);

            last_acc0 = req0_valid && req0_ready;
            last_acc1 = req1_valid && req1_ready;
            if (last_acc0) acc_q.push_back('{1'b0, cyc});
            if (last_acc1) acc_q.push_back('{1'b1, cyc});
            if (rsp_valid && rsp_ready)
                rsp_q.push_back('{rsp_id, rsp_result, rsp_carryout, rsp_overflow, rsp_zero, cyc});

            if (!m_busy && w_vld) begin
                m_busy = 1; m_last = w_id; m_id = w_id; m_acc_cyc = cyc;
                m_op = w_id ? req1_opcode : req0_opcode;
                m_a  = w_id ? req1_A : req0_A;
                m_b  = w_id ? req1_B : req0_B;
                m_exp = alu_fn(m_op, m_a, m_b);
            end else if (e_rv && rsp_ready) begin
                m_busy = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_req(input bit n);
        if (n == 1'b0) begin
            req0_valid = 1; req0_opcode = 3'($urandom_range(0, 7));
            req0_A = NB'($urandom); req0_B = NB'($urandom);
        end else begin
            req1_valid = 1; req1_opcode = 3'($urandom_range(0, 7));
            req1_A = NB'($urandom); req1_B = NB'($urandom);
        end
    endtask

    task automatic reset_dut();
        req0_valid = 0; req1_valid = 0; reset = 1;
        step();
        reset = 0;
    endtask

    task automatic run(input int tgt_acc, input int tgt_rsp, input bit refill);
        int k = 0;
        while ((acc_q.size() < tgt_acc || rsp_q.size() < tgt_rsp) && k < 200) begin
            step();
            k++;
            if (last_acc0) begin if (refill) rand_req(0); else req0_valid = 0; end
            if (last_acc1) begin if (refill) rand_req(1); else req1_valid = 0; end
        end
        chk("run_timeout", (k >= 200), 0);
    endtask

    task automatic drain();
        int k = 0;
        req0_valid = 0; req1_valid = 0; rsp_ready = 1;
        while ((busy || rsp_valid) && k < 50) begin step(); k++; end
        chk("drain_timeout", (k >= 50), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int na, nr, k;
        reset = 1; rsp_ready = 1;
        req0_valid = 0; req0_opcode = 0; req0_A = 0; req0_B = 0;
        req1_valid = 0; req1_opcode = 0; req1_A = 0; req1_B = 0;
        repeat (2) step();
        reset = 0;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_alu_A", alu_A, 0);
        chk("rst_alu_opcode", alu_opcode, 0);
        chk("rst_rsp_result", rsp_result, 0);

        // Tie straight after reset: requester 0 first, then 1.
        na = acc_q.size(); nr = rsp_q.size();
        req0_valid = 1; req0_opcode = 3'b110; req0_A = 8'h0F; req0_B = 8'hF0;
        req1_valid = 1; req1_opcode = 3'b010; req1_A = 8'hFF; req1_B = 8'hFF;
        run(na + 2, nr + 2, 0);
        chk("tie_first_id", rsp_q[nr].id, 0);
        chk("tie_first_res", rsp_q[nr].res, 8'hFF);
        chk("tie_first_zero", rsp_q[nr].z, 0);
        chk("tie_second_id", rsp_q[nr+1].id, 1);
        chk("tie_second_res", rsp_q[nr+1].res, 8'h00);
        chk("tie_second_zero", rsp_q[nr+1].z, 1);

        // Single op: FF + 01 unsigned.
        na = acc_q.size(); nr = rsp_q.size();
        req0_valid = 1; req0_opcode = 3'b000; req0_A = 8'hFF; req0_B = 8'h01;
        run(na + 1, nr + 1, 0);
        chk("single_id", rsp_q[nr].id, 0);
        chk("single_res", rsp_q[nr].res, 8'h00);
        chk("single_carry", rsp_q[nr].c, 1);
        chk("single_zero", rsp_q[nr].z, 1);
        chk("single_latency", rsp_q[nr].cyc - acc_q[na].cyc, 3);
        chk("single_accepts", acc_q.size() - na, 1);

        // Both held valid for six grants.
        reset_dut();
        na = acc_q.size();
        rand_req(0); rand_req(1);
        run(na + 6, 0, 1);
        drain();
        for (int i = 0; i < 6; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            chk("rr_grant_id", acc_q[na+i].id, 0);
`else
            chk("rr_grant_id", acc_q[na+i].id, i % 2);
`endif
        end

        // Response backpressure with requester 1 pending.
        na = acc_q.size();
        rsp_ready = 0;
        rand_req(0);
        run(na + 1, 0, 0);
        rand_req(1);
        k = 0;
        while (!rsp_valid && k < 20) begin step(); k++; end
        chk("bp_wait_rsp", (k >= 20), 0);
        repeat (10) begin
            step();
            chk("bp_busy", busy, 1);
            chk("bp_req1_ready", req1_ready, 0);
        end
        nr = rsp_q.size();
        rsp_ready = 1;
        run(na + 2, nr + 1, 0);
        chk("bp_accept_id", acc_q[na+1].id, 1);
        chk("bp_accept_gap", acc_q[na+1].cyc - rsp_q[nr].cyc, 1);
        drain();

        // Reset while the op sits in EXEC with cnt 0.
        na = acc_q.size();
        req0_valid = 1; req0_opcode = 3'b101; req0_A = 8'h3C; req0_B = 8'h41;
        run(na + 1, 0, 0);
        chk("abort_alu_A_before", alu_A, 8'h3C);
        reset = 1;
        step();
        reset = 0;
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_alu_A", alu_A, 0);
        nr = rsp_q.size();
        repeat (12) step();
        chk("abort_no_rsp", rsp_q.size() - nr, 0);

        // Operand change after accept must not reach the ALU.
        na = acc_q.size(); nr = rsp_q.size();
        req0_valid = 1; req0_opcode = 3'b111; req0_A = 8'h12; req0_B = 8'hA5;
        run(na + 1, 0, 0);
        req0_A = 8'h55;
        step();
        chk("stab_alu_A", alu_A, 8'h12);
        run(na + 1, nr + 1, 0);
        chk("stab_res", rsp_q[nr].res, 8'h09);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step();
            rsp_ready = ($urandom_range(0, 3) != 0);
            if (last_acc0) req0_valid = 0;
            else if (req0_valid && $urandom_range(0, 15) == 0) req0_valid = 0;
            if (!req0_valid && $urandom_range(0, 1) == 1) rand_req(0);
            if (last_acc1) req1_valid = 0;
            else if (req1_valid && $urandom_range(0, 15) == 0) req1_valid = 0;
            if (!req1_valid && $urandom_range(0, 1) == 1) rand_req(1);
        end
        drain();
        repeat (2) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
